// File: rtl/gcd_param_unit.sv
// Multi-mode GCD engine (subtractive Euclid or binary Stein) with a result FIFO.
// Operands are accepted in IDLE; results are pushed in job order and popped by the consumer.
module gcd_param_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MODE  = 0,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         input_available,
  input  logic [WIDTH-1:0]             operand_A,
  input  logic [WIDTH-1:0]             operand_B,
  input  logic                         result_taken,
  output logic                         idle,
  output logic                         result_rdy,
  output logic [WIDTH-1:0]             result_data,
  output logic [$clog2(DEPTH+1)-1:0]   result_count
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_CALC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             idle_q, idle_d, rdy_q, rdy_d;

  logic [WIDTH-1:0] a_step, b_step, push_val;
  logic [KW-1:0]    k_step;
  logic             push_req, push, pop, fifo_full;

  // One algorithm step on the current A/B/k, or a push request when finished
  always_comb begin
    a_step   = a_q;
    b_step   = b_q;
    k_step   = k_q;
    push_req = 1'b0;
    push_val = '0;
    if (MODE == 0) begin
      if (a_q < b_q) begin
        a_step = b_q;
        b_step = a_q;
      end else if (b_q != '0) begin
        a_step = a_q - b_q;
      end else begin
        push_req = 1'b1;
        push_val = a_q;
      end
    end else begin
      if (b_q == '0) begin
        push_req = 1'b1;
        push_val = WIDTH'(a_q << k_q);
      end else if (a_q == '0) begin
        push_req = 1'b1;
        push_val = WIDTH'(b_q << k_q);
      end else if (!a_q[0] && !b_q[0]) begin
        a_step = a_q >> 1;
        b_step = b_q >> 1;
        k_step = k_q + KW'(1);
      end else if (!a_q[0]) begin
        a_step = a_q >> 1;
      end else if (!b_q[0]) begin
        b_step = b_q >> 1;
      end else if (a_q >= b_q) begin
        a_step = a_q - b_q;
      end else begin
        b_step = b_q - a_q;
      end
    end
  end

  // Next-state, FIFO bookkeeping and registered-output values
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    fifo_full = (count_q == CW'(DEPTH));
    pop       = result_taken && (count_q != '0);
    push      = (state_q == S_CALC) && push_req && (!fifo_full || pop);

    case (state_q)
      S_IDLE: begin
        if (input_available) begin
          state_d = S_CALC;
          a_d     = operand_A;
          b_d     = operand_B;
          k_d     = '0;
        end
      end
      S_CALC: begin
        if (push) begin
          state_d = S_IDLE;
        end else if (!push_req) begin
          a_d = a_step;
          b_d = b_step;
          k_d = k_step;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Head register tracks the entry that will sit at rd_ptr after this edge
    if (pop) begin
      if (count_q > CW'(1))  head_d = mem_q[rd_ptr_q + PW'(1)];
      else if (push)         head_d = push_val;
      else                   head_d = '0;
    end else if (push && (count_q == '0)) begin
      head_d = push_val;
    end

    idle_d = (state_d == S_IDLE);
    rdy_d  = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      idle_q   <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      idle_q   <= idle_d;
      rdy_q    <= rdy_d;
    end
  end

  // Result storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_val;
  end

  assign idle         = idle_q;
  assign result_rdy   = rdy_q;
  assign result_data  = head_q;
  assign result_count = count_q;

endmodule
